// File: rtl/combat_health_arbiter_if.sv
// rtl/combat_health_arbiter_if.sv - hit request/ack bus between the two attack pipelines and the health arbiter
interface combat_health_arbiter_if #(
    parameter int DMG_W = 4
);
    logic             p1_hit_req;
    logic [DMG_W-1:0] p1_hit_dmg;
    logic             p2_hit_req;
    logic [DMG_W-1:0] p2_hit_dmg;
    logic             p1_hit_ack;
    logic             p2_hit_ack;
    logic             hit_applied;

    // Attack pipelines: raise and hold a request until it is acked
    modport master (
        output p1_hit_req, p1_hit_dmg, p2_hit_req, p2_hit_dmg,
        input  p1_hit_ack, p2_hit_ack, hit_applied
    );

    // Arbiter: consumes requests one per cycle
    modport slave (
        input  p1_hit_req, p1_hit_dmg, p2_hit_req, p2_hit_dmg,
        output p1_hit_ack, p2_hit_ack, hit_applied
    );
endinterface

// File: rtl/combat_health_arbiter.sv
// rtl/combat_health_arbiter.sv - two-player health owner and hit arbiter; optional invincibility frames via COMBAT_IFRAME_EN
module combat_health_arbiter #(
    parameter int MAX_HEALTH    = 100,
    parameter int DMG_W         = 4,
    parameter int IFRAME_CYCLES = 30
) (
    input  logic                            clk_game,
    input  logic                            reset_n,
    input  logic                            reset_gameplay,
    input  logic                            gameplay_active,
    input  logic                            timer_expired,
    combat_health_arbiter_if.slave          hit_bus,
    output logic [7:0]                      p1_health,
    output logic [7:0]                      p2_health,
    output logic                            game_over_condition,
    output logic                            winner_p1,
    output logic                            winner_p2,
    output logic                            draw
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        OVER   = 2'd2
    } state_t;

    localparam logic [7:0] L_MAX_HEALTH = 8'(MAX_HEALTH);
    localparam logic       L_GRANT_P1   = 1'b0;
    localparam logic       L_GRANT_P2   = 1'b1;

    // Health is an 8-bit register and damage is zero-extended into it
    if (MAX_HEALTH > 255 || MAX_HEALTH < 1 || DMG_W > 8 || IFRAME_CYCLES < 1) begin : g_bad_param
        $error("combat_health_arbiter: illegal parameter set");
    end

    state_t     r_state, w_state_nxt;
    logic [7:0] r_p1_health, r_p2_health;
    logic       r_p1_ack, r_p2_ack, r_hit_applied;
    logic       r_game_over, r_win_p1, r_win_p2, r_draw;
    logic       r_last_grant;

    logic [DMG_W-1:0] w_p1_dmg_raw, w_p2_dmg_raw;
    logic [7:0] w_p1_dmg, w_p2_dmg;
    logic       w_p1_elig, w_p2_elig;
    logic       w_grant_p1, w_grant_p2, w_grant;
    logic       w_victim_blocked;
    logic       w_apply, w_kill;
    logic [7:0] w_dmg, w_victim_health, w_new_health;
    logic [7:0] w_p1_health_nxt, w_p2_health_nxt;
    logic       w_game_over_nxt, w_win_p1_nxt, w_win_p2_nxt, w_draw_nxt;

    assign w_p1_dmg_raw = hit_bus.p1_hit_dmg;
    assign w_p2_dmg_raw = hit_bus.p2_hit_dmg;
    assign w_p1_dmg     = 8'(w_p1_dmg_raw);
    assign w_p2_dmg     = 8'(w_p2_dmg_raw);

    // A request whose ack is showing this cycle is the one just consumed, not a new hit
    assign w_p1_elig = hit_bus.p1_hit_req & ~r_p1_ack;
    assign w_p2_elig = hit_bus.p2_hit_req & ~r_p2_ack;

    // Round-robin on a tie; requests are never granted while idle
    assign w_grant_p1 = (r_state != IDLE) & w_p1_elig & (~w_p2_elig | (r_last_grant == L_GRANT_P2));
    assign w_grant_p2 = (r_state != IDLE) & w_p2_elig & ~w_grant_p1;
    assign w_grant    = w_grant_p1 | w_grant_p2;

`ifdef COMBAT_IFRAME_EN
    localparam int              IFW      = $clog2(IFRAME_CYCLES + 1);
    localparam logic [IFW-1:0]  L_IFRAME = IFW'(IFRAME_CYCLES);

    logic [IFW-1:0] r_p1_iframe, r_p2_iframe;

    assign w_victim_blocked = w_grant_p1 ? (r_p2_iframe != '0) : (r_p1_iframe != '0);

    // Invincibility windows: reload on a damaging hit, otherwise count down to zero
    always_ff @(posedge clk_game or negedge reset_n) begin
        if (!reset_n) begin
            r_p1_iframe <= '0;
            r_p2_iframe <= '0;
        end else if (reset_gameplay) begin
            r_p1_iframe <= '0;
            r_p2_iframe <= '0;
        end else begin
            if (w_apply && w_grant_p2 && (w_dmg != 8'd0))
                r_p1_iframe <= L_IFRAME;
            else if (r_p1_iframe != '0)
                r_p1_iframe <= r_p1_iframe - 1'b1;
            if (w_apply && w_grant_p1 && (w_dmg != 8'd0))
                r_p2_iframe <= L_IFRAME;
            else if (r_p2_iframe != '0)
                r_p2_iframe <= r_p2_iframe - 1'b1;
        end
    end
`else
    assign w_victim_blocked = 1'b0;
`endif

    // Damage only lands during live play; in OVER the grant is a pure drain
    assign w_apply         = w_grant & (r_state == ACTIVE) & ~w_victim_blocked;
    assign w_dmg           = w_grant_p1 ? w_p1_dmg : w_p2_dmg;
    assign w_victim_health = w_grant_p1 ? r_p2_health : r_p1_health;
    assign w_new_health    = (w_victim_health > w_dmg) ? (w_victim_health - w_dmg) : 8'd0;
    assign w_kill          = w_apply & (w_new_health == 8'd0);
    assign w_p1_health_nxt = (w_apply & w_grant_p2) ? w_new_health : r_p1_health;
    assign w_p2_health_nxt = (w_apply & w_grant_p1) ? w_new_health : r_p2_health;

    // FSM state register
    always_ff @(posedge clk_game or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else if (reset_gameplay)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next state and end-of-round verdict; a kill outranks the timer on the same edge
    always_comb begin
        w_state_nxt     = r_state;
        w_game_over_nxt = r_game_over;
        w_win_p1_nxt    = r_win_p1;
        w_win_p2_nxt    = r_win_p2;
        w_draw_nxt      = r_draw;
        case (r_state)
            IDLE: begin
                if (gameplay_active)
                    w_state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (w_kill) begin
                    w_state_nxt     = OVER;
                    w_game_over_nxt = 1'b1;
                    w_win_p1_nxt    = w_grant_p1;
                    w_win_p2_nxt    = w_grant_p2;
                    w_draw_nxt      = 1'b0;
                end else if (timer_expired) begin
                    w_state_nxt     = OVER;
                    w_game_over_nxt = 1'b1;
                    w_win_p1_nxt    = (w_p1_health_nxt > w_p2_health_nxt);
                    w_win_p2_nxt    = (w_p2_health_nxt > w_p1_health_nxt);
                    w_draw_nxt      = (w_p1_health_nxt == w_p2_health_nxt);
                end else if (!gameplay_active) begin
                    w_state_nxt = IDLE;
                end
            end
            OVER: begin
                w_state_nxt = OVER;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Registered grant, health update and latched round result
    always_ff @(posedge clk_game or negedge reset_n) begin
        if (!reset_n) begin
            r_p1_health   <= L_MAX_HEALTH;
            r_p2_health   <= L_MAX_HEALTH;
            r_p1_ack      <= 1'b0;
            r_p2_ack      <= 1'b0;
            r_hit_applied <= 1'b0;
            r_game_over   <= 1'b0;
            r_win_p1      <= 1'b0;
            r_win_p2      <= 1'b0;
            r_draw        <= 1'b0;
            r_last_grant  <= L_GRANT_P2;
        end else if (reset_gameplay) begin
            r_p1_health   <= L_MAX_HEALTH;
            r_p2_health   <= L_MAX_HEALTH;
            r_p1_ack      <= 1'b0;
            r_p2_ack      <= 1'b0;
            r_hit_applied <= 1'b0;
            r_game_over   <= 1'b0;
            r_win_p1      <= 1'b0;
            r_win_p2      <= 1'b0;
            r_draw        <= 1'b0;
            r_last_grant  <= L_GRANT_P2;
        end else begin
            r_p1_health   <= w_p1_health_nxt;
            r_p2_health   <= w_p2_health_nxt;
            r_p1_ack      <= w_grant_p1;
            r_p2_ack      <= w_grant_p2;
            r_hit_applied <= w_apply;
            r_game_over   <= w_game_over_nxt;
            r_win_p1      <= w_win_p1_nxt;
            r_win_p2      <= w_win_p2_nxt;
            r_draw        <= w_draw_nxt;
            if (w_grant)
                r_last_grant <= w_grant_p2 ? L_GRANT_P2 : L_GRANT_P1;
        end
    end

    assign hit_bus.p1_hit_ack  = r_p1_ack;
    assign hit_bus.p2_hit_ack  = r_p2_ack;
    assign hit_bus.hit_applied = r_hit_applied;
    assign p1_health           = r_p1_health;
    assign p2_health           = r_p2_health;
    assign game_over_condition = r_game_over;
    assign winner_p1           = r_win_p1;
    assign winner_p2           = r_win_p2;
    assign draw                = r_draw;

endmodule

// File: tb/tb_combat_health_arbiter.sv
// tb/tb_combat_health_arbiter.sv - directed self-checking bench for combat_health_arbiter
module tb_combat_health_arbiter;

`ifdef COMBAT_IFRAME_EN
    localparam int IF_ON = 1;
    localparam int GAP   = 31;
`else
    localparam int IF_ON = 0;
    localparam int GAP   = 0;
`endif

    logic       clk_game = 1'b0;
    logic       reset_n = 1'b0;
    logic       reset_gameplay = 1'b0;
    logic       gameplay_active = 1'b0;
    logic       timer_expired = 1'b0;
    logic [7:0] p1_health, p2_health;
    logic       game_over_condition, winner_p1, winner_p2, draw;

    int checks = 0;
    int failures = 0;
    logic cap_ack1, cap_ack2, cap_app;

    combat_health_arbiter_if #(.DMG_W(4)) bus ();

    combat_health_arbiter #(.MAX_HEALTH(100), .DMG_W(4), .IFRAME_CYCLES(30)) dut (
        .clk_game            (clk_game),
        .reset_n             (reset_n),
        .reset_gameplay      (reset_gameplay),
        .gameplay_active     (gameplay_active),
        .timer_expired       (timer_expired),
        .hit_bus             (bus),
        .p1_health           (p1_health),
        .p2_health           (p2_health),
        .game_over_condition (game_over_condition),
        .winner_p1           (winner_p1),
        .winner_p2           (winner_p2),
        .draw                (draw)
    );

    always #5 clk_game = ~clk_game;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_game);
        #1;
    endtask

    // One request held until acked, then one idle cycle so the next request is seen as new
    task automatic do_hit(input int who, input int dmg);
        if (who == 1) begin bus.p1_hit_dmg = 4'(dmg); bus.p1_hit_req = 1'b1; end
        else          begin bus.p2_hit_dmg = 4'(dmg); bus.p2_hit_req = 1'b1; end
        step();
        cap_ack1 = bus.p1_hit_ack;
        cap_ack2 = bus.p2_hit_ack;
        cap_app  = bus.hit_applied;
        bus.p1_hit_req = 1'b0;
        bus.p2_hit_req = 1'b0;
        step();
    endtask

    task automatic hit_n(input int who, input int dmg, input int n);
        for (int k = 0; k < n; k++) begin
            do_hit(who, dmg);
            repeat (GAP) @(posedge clk_game);
            #1;
        end
    endtask

    task automatic go_fresh();
        timer_expired = 1'b0;
        gameplay_active = 1'b1;
        reset_gameplay = 1'b1;
        step();
        reset_gameplay = 1'b0;
        step();
    endtask

    task automatic test_reset();
        bus.p1_hit_req = 1'b0; bus.p2_hit_req = 1'b0;
        bus.p1_hit_dmg = '0;   bus.p2_hit_dmg = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk_game);
        #1;
        reset_n = 1'b1;
        step();
        checks++; if (p1_health !== 8'd100) begin failures++; $display("FAIL reset_p1_health got=%0d exp=100", p1_health); end
        checks++; if (p2_health !== 8'd100) begin failures++; $display("FAIL reset_p2_health got=%0d exp=100", p2_health); end
        checks++; if ({game_over_condition, winner_p1, winner_p2, draw} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {game_over_condition, winner_p1, winner_p2, draw}); end
        gameplay_active = 1'b1;
        step();
        checks++; if ({bus.p1_hit_ack, bus.p2_hit_ack, bus.hit_applied} !== 3'b000) begin failures++; $display("FAIL reset_acks got=%b exp=000", {bus.p1_hit_ack, bus.p2_hit_ack, bus.hit_applied}); end
    endtask

    task automatic test_single_hit();
        bus.p1_hit_dmg = 4'd10;
        bus.p1_hit_req = 1'b1;
        step();
        checks++; if (bus.p1_hit_ack !== 1'b1) begin failures++; $display("FAIL single_ack got=%b exp=1", bus.p1_hit_ack); end
        checks++; if (bus.hit_applied !== 1'b1) begin failures++; $display("FAIL single_applied got=%b exp=1", bus.hit_applied); end
        checks++; if (p2_health !== 8'd90) begin failures++; $display("FAIL single_p2_health got=%0d exp=90", p2_health); end
        step();
        checks++; if (bus.p1_hit_ack !== 1'b0) begin failures++; $display("FAIL held_req_no_reack got=%b exp=0", bus.p1_hit_ack); end
        checks++; if (p2_health !== 8'd90) begin failures++; $display("FAIL held_req_health got=%0d exp=90", p2_health); end
        bus.p1_hit_req = 1'b0;
        step();
    endtask

    task automatic test_idle_hold();
        gameplay_active = 1'b0;
        step();
        bus.p2_hit_dmg = 4'd7;
        bus.p2_hit_req = 1'b1;
        repeat (3) @(posedge clk_game);
        #1;
        checks++; if (bus.p2_hit_ack !== 1'b0) begin failures++; $display("FAIL idle_no_ack got=%b exp=0", bus.p2_hit_ack); end
        checks++; if (p1_health !== 8'd100) begin failures++; $display("FAIL idle_p1_health got=%0d exp=100", p1_health); end
        gameplay_active = 1'b1;
        step();
        checks++; if (bus.p2_hit_ack !== 1'b0) begin failures++; $display("FAIL idle_exit_ack got=%b exp=0", bus.p2_hit_ack); end
        step();
        checks++; if (bus.p2_hit_ack !== 1'b1) begin failures++; $display("FAIL idle_release_ack got=%b exp=1", bus.p2_hit_ack); end
        checks++; if (p1_health !== 8'd93) begin failures++; $display("FAIL idle_release_health got=%0d exp=93", p1_health); end
        bus.p2_hit_req = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        go_fresh();
        bus.p1_hit_dmg = 4'd5; bus.p2_hit_dmg = 4'd5;
        bus.p1_hit_req = 1'b1; bus.p2_hit_req = 1'b1;
        step();
        checks++; if ({bus.p1_hit_ack, bus.p2_hit_ack} !== 2'b10) begin failures++; $display("FAIL rr_first got=%b exp=10", {bus.p1_hit_ack, bus.p2_hit_ack}); end
        checks++; if (p2_health !== 8'd95) begin failures++; $display("FAIL rr_first_p2_health got=%0d exp=95", p2_health); end
        bus.p1_hit_req = 1'b0;
        step();
        checks++; if ({bus.p1_hit_ack, bus.p2_hit_ack} !== 2'b01) begin failures++; $display("FAIL rr_second got=%b exp=01", {bus.p1_hit_ack, bus.p2_hit_ack}); end
        checks++; if (p1_health !== 8'd95) begin failures++; $display("FAIL rr_second_p1_health got=%0d exp=95", p1_health); end
        bus.p2_hit_req = 1'b0;
        step();
        bus.p1_hit_req = 1'b1; bus.p2_hit_req = 1'b1;
        step();
        checks++; if ({bus.p1_hit_ack, bus.p2_hit_ack} !== 2'b10) begin failures++; $display("FAIL rr_third got=%b exp=10", {bus.p1_hit_ack, bus.p2_hit_ack}); end
        checks++; if (p2_health !== ((IF_ON != 0) ? 8'd95 : 8'd90)) begin failures++; $display("FAIL rr_third_p2_health got=%0d exp=%0d", p2_health, (IF_ON != 0) ? 95 : 90); end
        bus.p1_hit_req = 1'b0; bus.p2_hit_req = 1'b0;
        step();
    endtask

    task automatic test_iframes();
        go_fresh();
        do_hit(1, 3);
        checks++; if ({cap_ack1, cap_app} !== 2'b11) begin failures++; $display("FAIL if_first got=%b exp=11", {cap_ack1, cap_app}); end
        checks++; if (p2_health !== 8'd97) begin failures++; $display("FAIL if_first_health got=%0d exp=97", p2_health); end
        repeat (8) @(posedge clk_game);
        #1;
        do_hit(1, 3);
        checks++; if (cap_ack1 !== 1'b1) begin failures++; $display("FAIL if_second_ack got=%b exp=1", cap_ack1); end
        checks++; if (cap_app !== ((IF_ON != 0) ? 1'b0 : 1'b1)) begin failures++; $display("FAIL if_second_applied got=%b exp=%0d", cap_app, (IF_ON != 0) ? 0 : 1); end
        checks++; if (p2_health !== ((IF_ON != 0) ? 8'd97 : 8'd94)) begin failures++; $display("FAIL if_second_health got=%0d exp=%0d", p2_health, (IF_ON != 0) ? 97 : 94); end
        repeat (19) @(posedge clk_game);
        #1;
        do_hit(1, 3);
        checks++; if ({cap_ack1, cap_app} !== 2'b11) begin failures++; $display("FAIL if_third got=%b exp=11", {cap_ack1, cap_app}); end
        checks++; if (p2_health !== ((IF_ON != 0) ? 8'd94 : 8'd91)) begin failures++; $display("FAIL if_third_health got=%0d exp=%0d", p2_health, (IF_ON != 0) ? 94 : 91); end
    endtask

    task automatic test_kill();
        go_fresh();
        hit_n(1, 15, 6);
        hit_n(1, 2, 1);
        checks++; if (p2_health !== 8'd8) begin failures++; $display("FAIL kill_setup got=%0d exp=8", p2_health); end
        hit_n(1, 15, 1);
        checks++; if (p2_health !== 8'd0) begin failures++; $display("FAIL kill_saturate got=%0d exp=0", p2_health); end
        checks++; if ({game_over_condition, winner_p1, winner_p2, draw} !== 4'b1100) begin failures++; $display("FAIL kill_flags got=%b exp=1100", {game_over_condition, winner_p1, winner_p2, draw}); end
        hit_n(2, 4, 1);
        checks++; if ({cap_ack2, cap_app} !== 2'b10) begin failures++; $display("FAIL over_drain got=%b exp=10", {cap_ack2, cap_app}); end
        checks++; if (p1_health !== 8'd100) begin failures++; $display("FAIL over_frozen got=%0d exp=100", p1_health); end
        reset_gameplay = 1'b1;
        step();
        reset_gameplay = 1'b0;
        checks++; if ({p1_health, p2_health} !== {8'd100, 8'd100}) begin failures++; $display("FAIL rg_health got=%0d/%0d exp=100/100", p1_health, p2_health); end
        checks++; if ({game_over_condition, winner_p1, winner_p2, draw} !== 4'b0000) begin failures++; $display("FAIL rg_flags got=%b exp=0000", {game_over_condition, winner_p1, winner_p2, draw}); end
    endtask

    task automatic test_timer();
        go_fresh();
        hit_n(1, 15, 4);
        hit_n(2, 15, 2);
        hit_n(2, 10, 1);
        timer_expired = 1'b1;
        step();
        timer_expired = 1'b0;
        checks++; if ({p1_health, p2_health} !== {8'd60, 8'd40}) begin failures++; $display("FAIL timer_setup got=%0d/%0d exp=60/40", p1_health, p2_health); end
        checks++; if ({game_over_condition, winner_p1, winner_p2, draw} !== 4'b1100) begin failures++; $display("FAIL timer_p1_wins got=%b exp=1100", {game_over_condition, winner_p1, winner_p2, draw}); end
        go_fresh();
        hit_n(1, 15, 3); hit_n(1, 5, 1);
        hit_n(2, 15, 3); hit_n(2, 5, 1);
        timer_expired = 1'b1;
        step();
        timer_expired = 1'b0;
        checks++; if ({game_over_condition, winner_p1, winner_p2, draw} !== 4'b1001) begin failures++; $display("FAIL timer_draw got=%b exp=1001", {game_over_condition, winner_p1, winner_p2, draw}); end
        go_fresh();
        hit_n(1, 15, 6);
        hit_n(2, 15, 6);
        bus.p2_hit_dmg = 4'd15;
        bus.p2_hit_req = 1'b1;
        timer_expired = 1'b1;
        step();
        timer_expired = 1'b0;
        bus.p2_hit_req = 1'b0;
        checks++; if ({bus.p2_hit_ack, p1_health} !== {1'b1, 8'd0}) begin failures++; $display("FAIL kill_timer_hit got=%b/%0d exp=1/0", bus.p2_hit_ack, p1_health); end
        checks++; if ({game_over_condition, winner_p1, winner_p2, draw} !== 4'b1010) begin failures++; $display("FAIL kill_timer_flags got=%b exp=1010", {game_over_condition, winner_p1, winner_p2, draw}); end
        step();
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_idle_hold();
        test_round_robin();
        test_iframes();
        test_kill();
        test_timer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/combat_health_arbiter.md
Name: combat_health_arbiter

Overview:
- Owns both players' health registers during gameplay and arbitrates hit requests from the two attack pipelines onto a single health-update path (one update per clk_game cycle).
- Applies damage with saturation and optional invincibility frames.
- Produces game_over_condition, winner_p1 and winner_p2 for game_state_controller.
- Sits between the per-player combat/hitbox logic and the game state controller. It is cleared by that controller's reset_gameplay and gated by its gameplay state.

Parameters:
- MAX_HEALTH, 100, starting and reset health per player (must be ≤ 255).
- DMG_W, 4, width of the damage fields.
- IFRAME_CYCLES, 30, number of clk_game cycles a victim ignores hits after taking damage (only with COMBAT_IFRAME_EN).

Ports:
- clk_game  in  1  60 Hz game clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- reset_gameplay  in  1  synchronous clear, active high; overrides everything except reset_n.
- gameplay_active  in  1  high while the game state is GAMEPLAY.
- timer_expired  in  1  round time is over; level, sampled every cycle.
- p1_hit_req  in  1  P1 has landed a hit on P2; held until p1_hit_ack.
- p1_hit_dmg  in  DMG_W  damage to P2; stable while p1_hit_req is high.
- p2_hit_req  in  1  P2 has landed a hit on P1; held until p2_hit_ack.
- p2_hit_dmg  in  DMG_W  damage to P1.
- p1_hit_ack  out  1  one-cycle pulse: P1's request is consumed.
- p2_hit_ack  out  1  one-cycle pulse: P2's request is consumed.
- hit_applied  out  1  valid with an ack: 1 = damage applied, 0 = dropped.
- p1_health  out  8  current P1 health.
- p2_health  out  8  current P2 health.
- game_over_condition  out  1  latched end-of-round flag.
- winner_p1  out  1  P1 won; valid while game_over_condition is high.
- winner_p2  out  1  P2 won.
- draw  out  1  round ended with equal health.

Behaviour:
- **Reset values** (reset_n low, or reset_gameplay high at an edge):
  - p1_health = p2_health = MAX_HEALTH.
  - All acks, hit_applied, game_over_condition, winner and draw flags = 0.
  - Invincibility counters = 0.
  - last_grant = P2, so P1 wins the first tie.
- **FSM states:** IDLE, ACTIVE, OVER.
  - IDLE → ACTIVE when gameplay_active is high.
  - ACTIVE → IDLE when gameplay_active drops and no game over has occurred. Health is held.
  - ACTIVE → OVER when either health reaches 0, or on timer_expired.
  - OVER exits only via reset_gameplay or reset_n.
- **Eligibility:** a requester is eligible when its req is high and its ack is not high in the current cycle. This prevents double-counting a held req.
- **Arbitration (ACTIVE only):**
  - If exactly one requester is eligible, it is granted.
  - If both are eligible, grant the one that is not last_grant (round-robin). Update last_grant on every grant.
- **Grant latency:** the grant is registered. On the same rising edge, ack = 1 and the victim's health is updated. Latency is 1 cycle from an eligible request. Only one ack per cycle.
- **Damage arithmetic:**
  - New health = health − dmg, saturating at 0. Zero-extend dmg to 8 bits.
  - dmg = 0 counts as applied with no change.
- **Game over on health:** when an update makes health 0, game_over_condition = 1 on that edge and the attacker's winner flag is set.
- **Game over on timer** (timer_expired in ACTIVE, with no update reaching 0 on that edge):
  - Higher health wins.
  - Equal health → draw = 1 and both winner flags = 0.
- **Timer and kill on the same edge:** the kill takes priority.
- **Requests in OVER:** still acked one per cycle, round-robin, with hit_applied = 0. Health is frozen.
- **Requests in IDLE:** no ack is issued; requesters wait.
- **Flag latching:** winner flags are latched. Exactly one of winner_p1, winner_p2 or draw is high in OVER; all three are 0 otherwise.
- **Reset mid-grant:** any pending ack is lost, and requesters must re-request.

Optional Feature:
- **Macro:** COMBAT_IFRAME_EN.
- **When defined:**
  - Each victim has an invincibility counter. It loads IFRAME_CYCLES on an applied hit with nonzero damage and decrements once per cycle to 0.
  - A hit against a victim whose counter is nonzero is acked with hit_applied = 0 and health unchanged.
  - The counter is cleared on reset and on reset_gameplay.
- **When undefined:** no counters exist, and every ACTIVE grant applies damage.

Test Plan:
1. Release reset_n and raise gameplay_active → p1_health = p2_health = 100; all flags 0; no acks.
2. p1_hit_req with dmg 10 → p1_hit_ack pulses 1 cycle later, hit_applied = 1, p2_health = 90. Req held one more cycle → no second ack in the ack cycle.
3. Both reqs raised on the same cycle, each dmg 5, after reset → first cycle: P1 acked, p2_health = 95. Next cycle: P2 acked, p1_health = 95. Next tie → P1 granted again.
4. With COMBAT_IFRAME_EN: P1 hits with dmg 3 twice, 10 cycles apart → second ack has hit_applied = 0 and p2_health stays 97. A hit 31 cycles after the first → applied, p2_health = 94. Without the macro → both applied.
5. p2_health = 8, P1 dmg 15 → p2_health = 0, game_over_condition = 1, winner_p1 = 1. A following p2_hit_req → acked with hit_applied = 0 and p1_health unchanged. reset_gameplay → all values back to reset.
6. timer_expired with health 60/40 → winner_p1 = 1. Repeat at 50/50 → draw = 1. timer_expired on the same edge as a kill → the kill's winner is reported and draw = 0.
